asi_seq_ctrl: RTL and testbench

ASI_SEQ_CTRL -- requirements
Module: asi_seq_ctrl

---
 rtl/asi_seq_if.sv | 32 +++
 rtl/asi_seq_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_asi_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/asi_seq_if.sv
// asi_seq_if -- handshake and datapath bundle for asi_seq_ctrl.
//   master : sequencer side (drives requests, strobes, pc/ra, instruction)
//   slave  : environment side (drives start, acks, fetched data, reg reads)
interface asi_seq_if;
   logic        start;
   logic        imem_req;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic [31:0] instruction;
   logic [31:0] data1;
   logic [31:0] data2;
   logic        write_enable;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ack;
   logic [31:0] pc;
   logic [31:0] ra;
   logic        busy;
   logic        fault;

   modport master (
      input  start, imem_ack, imem_data, data1, data2, dmem_ack,
      output imem_req, instruction, write_enable, dmem_req, dmem_we,
             pc, ra, busy, fault
   );

   modport slave (
      output start, imem_ack, imem_data, data1, data2, dmem_ack,
      input  imem_req, instruction, write_enable, dmem_req, dmem_we,
             pc, ra, busy, fault
   );
endinterface

// File: rtl/asi_seq_ctrl.sv
// asi_seq_ctrl -- multi-cycle instruction sequencer.
// Fetches an instruction, classifies its opcode, resolves branches/jumps,
// runs the data-memory handshake for loads/stores and strobes the
// register-file write for ALU ops and loads.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : asi_seq_if.master (start, imem/dmem handshakes, instruction,
//           data1/data2 compare inputs, write_enable, pc, ra, busy, fault)
// Build option: ASI_SEQ_TIMEOUT_EN adds a 15-cycle wait limit in FETCH/MEM
// that raises fault and halts.
//
// state    | meaning
// ---------+----------------------------------------------
// S_IDLE   | waiting for start
// S_FETCH  | imem_req high until imem_ack, then latch opcode
// S_DECODE | classify opcode; HALT on 0x00 or illegal
// S_EXEC   | resolve branch/jump, or route to MEM/WB
// S_MEM    | dmem_req high until dmem_ack
// S_WB     | one-cycle write_enable, pc += 4
// S_HALT   | parked until reset
module asi_seq_ctrl (
   input logic       clock,
   input logic       reset,
   asi_seq_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      C_ALU, C_BEQR, C_BNER, C_BEQI, C_BNEI, C_J, C_JAL, C_LOAD, C_STORE
   } cls_t;

   state_t      state;
   cls_t        cls;
   logic [7:0]  op;
   logic [31:0] pc_inc4;
   logic [31:0] pc_inc8;
   logic [31:0] br_tgt;
   logic [31:0] j_tgt;
   logic        reg_eq;
   logic        imm_eq;

`ifdef ASI_SEQ_TIMEOUT_EN
   logic [3:0]  wait_cnt;
`endif

   assign op      = bus.instruction[31:24];
   assign pc_inc4 = bus.pc + 32'd4;
   assign pc_inc8 = bus.pc + 32'd8;
   assign br_tgt  = bus.pc + {{22{bus.instruction[7]}}, bus.instruction[7:0], 2'b00};
   assign j_tgt   = {bus.pc[31:26], bus.instruction[23:0], 2'b00};
   assign reg_eq  = (bus.data1 == bus.data2);
   assign imm_eq  = (bus.data1 == {16'h0000, bus.instruction[15:0]});
   assign bus.busy = (state != S_IDLE) && (state != S_HALT);

   always_ff @(posedge clock) begin
      if (reset) begin
         state            <= S_IDLE;
         cls              <= C_ALU;
         bus.pc           <= '0;
         bus.ra           <= '0;
         bus.instruction  <= '0;
         bus.fault        <= 1'b0;
         bus.imem_req     <= 1'b0;
         bus.dmem_req     <= 1'b0;
         bus.dmem_we      <= 1'b0;
         bus.write_enable <= 1'b0;
`ifdef ASI_SEQ_TIMEOUT_EN
         wait_cnt         <= '0;
`endif
      end else begin
`ifdef ASI_SEQ_TIMEOUT_EN
         // only a stalled FETCH/MEM keeps counting; anything else clears
         wait_cnt <= '0;
`endif
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state        <= S_FETCH;
                  bus.imem_req <= 1'b1;
               end
            end
            S_FETCH: begin
               if (bus.imem_ack) begin
                  bus.instruction <= bus.imem_data;
                  bus.imem_req    <= 1'b0;
                  state           <= S_DECODE;
               end
`ifdef ASI_SEQ_TIMEOUT_EN
               else if (wait_cnt == 4'd14) begin
                  bus.imem_req <= 1'b0;
                  bus.fault    <= 1'b1;
                  state        <= S_HALT;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
`endif
            end
            S_DECODE: begin
               state <= S_EXEC;
               if ((op >= 8'h05 && op <= 8'h0A) || (op >= 8'h45 && op <= 8'h4C))
                  cls <= C_ALU;
               else if (op == 8'h41) cls <= C_BEQR;
               else if (op == 8'h42) cls <= C_BNER;
               else if (op == 8'h43) cls <= C_BEQI;
               else if (op == 8'h44) cls <= C_BNEI;
               else if (op == 8'h01) cls <= C_J;
               else if (op == 8'h02) cls <= C_JAL;
               else if (op == 8'h81 || op == 8'h82) cls <= C_LOAD;
               else if (op == 8'h83) cls <= C_STORE;
               else if (op == 8'h00) state <= S_HALT;
               else begin
                  bus.fault <= 1'b1;
                  state     <= S_HALT;
               end
            end
            S_EXEC: begin
               case (cls)
                  C_ALU: begin
                     bus.write_enable <= 1'b1;
                     state            <= S_WB;
                  end
                  C_LOAD: begin
                     bus.dmem_req <= 1'b1;
                     state        <= S_MEM;
                  end
                  C_STORE: begin
                     bus.dmem_req <= 1'b1;
                     bus.dmem_we  <= 1'b1;
                     state        <= S_MEM;
                  end
                  default: begin
                     bus.imem_req <= 1'b1;
                     state        <= S_FETCH;
                     case (cls)
                        C_BEQR:  bus.pc <= reg_eq  ? br_tgt  : pc_inc4;
                        C_BNER:  bus.pc <= !reg_eq ? br_tgt  : pc_inc4;
                        C_BEQI:  bus.pc <= imm_eq  ? pc_inc8 : pc_inc4;
                        C_BNEI:  bus.pc <= !imm_eq ? pc_inc8 : pc_inc4;
                        C_J:     bus.pc <= j_tgt;
                        C_JAL: begin
                           bus.pc <= j_tgt;
                           bus.ra <= pc_inc4;
                        end
                        default: bus.pc <= pc_inc4;
                     endcase
                  end
               endcase
            end
            S_MEM: begin
               if (bus.dmem_ack) begin
                  bus.dmem_req <= 1'b0;
                  bus.dmem_we  <= 1'b0;
                  if (cls == C_STORE) begin
                     bus.pc       <= pc_inc4;
                     bus.imem_req <= 1'b1;
                     state        <= S_FETCH;
                  end else begin
                     bus.write_enable <= 1'b1;
                     state            <= S_WB;
                  end
               end
`ifdef ASI_SEQ_TIMEOUT_EN
               else if (wait_cnt == 4'd14) begin
                  bus.dmem_req <= 1'b0;
                  bus.dmem_we  <= 1'b0;
                  bus.fault    <= 1'b1;
                  state        <= S_HALT;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
`endif
            end
            S_WB: begin
               bus.write_enable <= 1'b0;
               bus.pc           <= pc_inc4;
               bus.imem_req     <= 1'b1;
               state            <= S_FETCH;
            end
            S_HALT: state <= S_HALT;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_asi_seq_ctrl.sv
// tb_asi_seq_ctrl -- directed bench for asi_seq_ctrl.
module tb_asi_seq_ctrl;

   logic clock;
   logic reset;
   asi_seq_if bus ();

   asi_seq_ctrl dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int ncyc, we_cnt, we_at, dreq_cnt, dwe_cnt;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expects the DUT in FETCH with imem_req high; runs one instruction until
   // the next FETCH (or halt), acking dmem after dwait stalled MEM cycles.
   task automatic exec_instr(input logic [31:0] ins, input int dwait);
      bus.imem_data = ins;
      bus.imem_ack  = 1'b1;
      ncyc = 0; we_cnt = 0; we_at = 0; dreq_cnt = 0; dwe_cnt = 0;
      for (int i = 0; i < 24; i++) begin
         tick();
         ncyc++;
         bus.imem_ack = 1'b0;
         if (bus.write_enable) begin
            we_cnt++;
            we_at = ncyc + 1;
         end
         if (bus.dmem_req) begin
            dreq_cnt++;
            if (bus.dmem_we) dwe_cnt++;
            bus.dmem_ack = (dreq_cnt > dwait);
         end else begin
            bus.dmem_ack = 1'b0;
         end
         if (bus.imem_req || !bus.busy) break;
      end
      bus.dmem_ack = 1'b0;
   endtask

   task automatic restart();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.imem_ack  = 1'b0;
      bus.imem_data = '0;
      bus.data1     = '0;
      bus.data2     = '0;
      bus.dmem_ack  = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      chk("rst_pc", bus.pc, 32'h0);
      chk("rst_ra", bus.ra, 32'h0);
      chk("rst_instr", bus.instruction, 32'h0);
      chk("rst_fault", {31'b0, bus.fault}, 32'h0);
      chk("rst_busy", {31'b0, bus.busy}, 32'h0);
      chk("rst_imem_req", {31'b0, bus.imem_req}, 32'h0);
      chk("rst_dmem_req", {31'b0, bus.dmem_req}, 32'h0);
      chk("rst_we", {31'b0, bus.write_enable}, 32'h0);

      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("start_imem_req", {31'b0, bus.imem_req}, 32'h1);
      chk("start_busy", {31'b0, bus.busy}, 32'h1);

      // ALU-R
      exec_instr(32'h05030201, 0);
      chk("alu_cycles", ncyc, 4);
      chk("alu_we_cnt", we_cnt, 1);
      chk("alu_we_at", we_at, 4);
      chk("alu_pc", bus.pc, 32'h4);
      chk("alu_instr", bus.instruction, 32'h05030201);

      // J to 0x10
      exec_instr(32'h01000004, 0);
      chk("j_cycles", ncyc, 3);
      chk("j_pc", bus.pc, 32'h10);
      chk("j_we", we_cnt, 0);

      // BEQR taken / not taken
      bus.data1 = 32'd7; bus.data2 = 32'd7;
      exec_instr(32'h411D1E0A, 0);
      chk("beqr_taken_pc", bus.pc, 32'h38);
      chk("beqr_cycles", ncyc, 3);
      exec_instr(32'h01000004, 0);
      bus.data2 = 32'd8;
      exec_instr(32'h411D1E0A, 0);
      chk("beqr_nt_pc", bus.pc, 32'h14);

      // BNER taken with negative offset
      exec_instr(32'h420000FE, 0);
      chk("bner_neg_pc", bus.pc, 32'h0C);

      // BEQI taken / BNEI not taken
      bus.data1 = 32'h1234;
      exec_instr(32'h43001234, 0);
      chk("beqi_pc", bus.pc, 32'h14);
      exec_instr(32'h44001234, 0);
      chk("bnei_nt_pc", bus.pc, 32'h18);

      // JAL from 0x20
      exec_instr(32'h01000008, 0);
      chk("j2_pc", bus.pc, 32'h20);
      exec_instr(32'h02F0F0F0, 0);
      chk("jal_ra", bus.ra, 32'h24);
      chk("jal_pc", bus.pc, 32'h03C3C3C0);
      chk("jal_we", we_cnt, 0);

      // ALU-I
      exec_instr(32'h4C000000, 0);
      chk("alui_pc", bus.pc, 32'h03C3C3C4);
      chk("alui_we", we_cnt, 1);

      // STORE with 5 stall cycles
      exec_instr(32'h83640000, 5);
      chk("st_dreq", dreq_cnt, 6);
      chk("st_dwe", dwe_cnt, 6);
      chk("st_we", we_cnt, 0);
      chk("st_cycles", ncyc, 9);
      chk("st_pc", bus.pc, 32'h03C3C3C8);

      // LOAD zero-wait
      exec_instr(32'h81000000, 0);
      chk("ld_cycles", ncyc, 5);
      chk("ld_dreq", dreq_cnt, 1);
      chk("ld_dwe", dwe_cnt, 0);
      chk("ld_we", we_cnt, 1);
      chk("ld_pc", bus.pc, 32'h03C3C3CC);

      // pc wraparound: branch back from 0, then step over 0xFFFFFFFC
      restart();
      bus.data1 = 32'd5; bus.data2 = 32'd5;
      exec_instr(32'h410000FF, 0);
      chk("wrap_br_pc", bus.pc, 32'hFFFFFFFC);
      exec_instr(32'h06000000, 0);
      chk("wrap_alu_pc", bus.pc, 32'h0);

      // fetch stall with no ack
`ifdef ASI_SEQ_TIMEOUT_EN
      ncyc = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         ncyc++;
         if (!bus.busy) break;
      end
      chk("to_cycles", ncyc, 15);
      chk("to_fault", {31'b0, bus.fault}, 32'h1);
      chk("to_imem_req", {31'b0, bus.imem_req}, 32'h0);
`else
      for (int i = 0; i < 20; i++) tick();
      chk("stall_imem_req", {31'b0, bus.imem_req}, 32'h1);
      chk("stall_fault", {31'b0, bus.fault}, 32'h0);
      chk("stall_busy", {31'b0, bus.busy}, 32'h1);
`endif

      // illegal opcode
      restart();
      exec_instr(32'hFF000000, 0);
      chk("ill_cycles", ncyc, 2);
      chk("ill_fault", {31'b0, bus.fault}, 32'h1);
      chk("ill_busy", {31'b0, bus.busy}, 32'h0);
      bus.imem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.start = ~bus.start;
         tick();
      end
      bus.start = 1'b0;
      bus.imem_ack = 1'b0;
      chk("halt_imem_req", {31'b0, bus.imem_req}, 32'h0);
      chk("halt_busy", {31'b0, bus.busy}, 32'h0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("ill_rst_fault", {31'b0, bus.fault}, 32'h0);
      chk("ill_rst_pc", bus.pc, 32'h0);

      // reset mid data-memory handshake, ack arriving during reset
      restart();
      bus.imem_data = 32'h83640000;
      bus.imem_ack  = 1'b1;
      tick();
      bus.imem_ack = 1'b0;
      tick();
      tick();
      chk("mem_dreq", {31'b0, bus.dmem_req}, 32'h1);
      chk("mem_dwe", {31'b0, bus.dmem_we}, 32'h1);
      reset = 1'b1;
      bus.dmem_ack = 1'b1;
      tick();
      chk("mrst_dreq", {31'b0, bus.dmem_req}, 32'h0);
      chk("mrst_dwe", {31'b0, bus.dmem_we}, 32'h0);
      chk("mrst_busy", {31'b0, bus.busy}, 32'h0);
      chk("mrst_instr", bus.instruction, 32'h0);
      tick();
      reset = 1'b0;
      bus.dmem_ack = 1'b0;
      tick();
      chk("mrst_idle", {31'b0, bus.busy}, 32'h0);
      chk("mrst_pc", bus.pc, 32'h0);

      // HALT opcode: halts without fault
      restart();
      exec_instr(32'h00000000, 0);
      chk("halt_op_busy", {31'b0, bus.busy}, 32'h0);
      chk("halt_op_fault", {31'b0, bus.fault}, 32'h0);
      chk("halt_op_cycles", ncyc, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
